// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: PS/2 scan-code decoder with typematic repeat generation and an event FIFO
module ps2_key_sequencer #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_break,
  output logic       event_repeat,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'b00, EXT = 2'b01, BRK = 2'b10, EXT_BRK = 2'b11} state_t;
  state_t           r_state;
  logic             r_held_valid;
  logic [7:0]       r_held_code;
  logic             r_held_ext;
  logic [31:0]      r_timer;
  logic             r_pend;
  logic [10:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             w_drop, w_e0, w_f0, w_ext, w_brk, w_data, w_match;
  logic             w_make_new, w_brk_held, w_dec_push, w_rep_req, w_rep_push, w_push;
  logic             w_full, w_pop, w_wr;
  logic [10:0]      w_entry;
  assign w_drop     = scan_code inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFE, 8'hFF};
  assign w_e0       = scan_code == 8'hE0;
  assign w_f0       = scan_code == 8'hF0;
  assign w_ext      = r_state[0];
  assign w_brk      = r_state[1];
  // E0 seen after F0 (without a prior E0) is not a prefix, so it falls through as data
  assign w_data     = scan_valid && !w_drop && !w_f0 && !(w_e0 && r_state != BRK);
  assign w_match    = r_held_valid && r_held_code == scan_code && r_held_ext == w_ext;
  assign w_make_new = w_data && !w_brk && !w_match;
  assign w_brk_held = w_data && w_brk && w_match;
  assign w_dec_push = w_data && (w_brk || !w_match);
  assign w_rep_req  = r_held_valid && r_timer == 32'd0;
  assign w_rep_push = (w_rep_req || r_pend) && !w_dec_push;
  assign w_push     = w_dec_push || w_rep_push;
  assign w_entry    = w_dec_push ? {scan_code, w_ext, w_brk, 1'b0} : {r_held_code, r_held_ext, 2'b01};
  assign w_full     = r_count == CW'(FIFO_DEPTH);
  assign w_pop      = event_valid && event_ready;
  assign w_wr       = w_push && (!w_full || w_pop);
  assign event_valid = r_count != '0;
  assign {event_code, event_ext, event_break, event_repeat} = r_mem[r_rp];
  assign overflow   = r_overflow;
  // Prefix decoder: E0 sets the ext bit, F0 sets the break bit, data or dropped bytes return to IDLE
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else if (scan_valid)
      r_state <= w_drop ? IDLE
               : w_f0 ? state_t'({1'b1, r_state[0]})
               : (w_e0 && r_state != BRK) ? state_t'({r_state[1], 1'b1})
               : IDLE;
  end
  // Held-key tracker, repeat timer and the pending repeat that lost arbitration
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_held_valid <= 1'b0;
      r_held_code  <= 8'h00;
      r_held_ext   <= 1'b0;
      r_timer      <= 32'd0;
      r_pend       <= 1'b0;
    end else begin
      if (w_make_new) begin
        r_held_valid <= 1'b1;
        r_held_code  <= scan_code;
        r_held_ext   <= w_ext;
        r_timer      <= 32'(REPEAT_DELAY - 1);
      end else if (w_brk_held) begin
        r_held_valid <= 1'b0;
        r_timer      <= 32'd0;
      end else if (r_held_valid) r_timer <= w_rep_req ? 32'(REPEAT_RATE - 1) : r_timer - 32'd1;
      r_pend <= (w_make_new || w_brk_held) ? 1'b0 : (w_rep_req || r_pend) && w_dec_push;
    end
  end
  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end
  // FIFO storage needs no reset; occupancy gates its visibility
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wp] <= w_entry;
  end
endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb_ps2_key_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_ps2_key_sequencer;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_valid = 1'b0;
  logic       event_ready = 1'b0;
  logic       event_valid, event_ext, event_break, event_repeat, overflow;
  logic [7:0] event_code;
  int checks = 0;
  int errors = 0;

  ps2_key_sequencer #(.REPEAT_DELAY(10), .REPEAT_RATE(4), .FIFO_DEPTH(4)) dut (
    .clock(clock), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
    .event_ready(event_ready), .event_valid(event_valid), .event_code(event_code),
    .event_ext(event_ext), .event_break(event_break), .event_repeat(event_repeat),
    .overflow(overflow));

  always #5 clock = ~clock;

  typedef struct {
    logic       sv;
    logic [7:0] code;
    logic       rdy;
    logic       ev;
    logic [7:0] ec;
    logic       ee, eb, er;
  } vec_t;
  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input logic v, input logic [7:0] c,
                        input logic e, input logic b, input logic r);
    chk({name, ".valid"}, {31'd0, event_valid}, {31'd0, v});
    if (v) chk({name, ".head"}, {21'd0, event_code, event_ext, event_break, event_repeat},
               {21'd0, c, e, b, r});
  endtask

  task automatic cyc(input logic sv, input logic [7:0] code, input logic rdy);
    scan_valid = sv;
    scan_code = code;
    event_ready = rdy;
    @(posedge clock);
    #1;
    scan_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] keys [6];
    logic [7:0] drain [4];
    vt[0]  = '{1, 8'h1C, 1, 1, 8'h1C, 0, 0, 0};
    vt[1]  = '{1, 8'hF0, 1, 0, 8'h00, 0, 0, 0};
    vt[2]  = '{1, 8'h1C, 1, 1, 8'h1C, 0, 1, 0};
    vt[3]  = '{1, 8'hE0, 1, 0, 8'h00, 0, 0, 0};
    vt[4]  = '{1, 8'hF0, 1, 0, 8'h00, 0, 0, 0};
    vt[5]  = '{1, 8'h75, 1, 1, 8'h75, 1, 1, 0};
    vt[6]  = '{1, 8'hE0, 1, 0, 8'h00, 0, 0, 0};
    vt[7]  = '{1, 8'hAA, 1, 0, 8'h00, 0, 0, 0};
    vt[8]  = '{1, 8'h1C, 1, 1, 8'h1C, 0, 0, 0};
    vt[9]  = '{1, 8'hF0, 1, 0, 8'h00, 0, 0, 0};
    vt[10] = '{1, 8'h1C, 1, 1, 8'h1C, 0, 1, 0};
    vt[11] = '{1, 8'hE0, 1, 0, 8'h00, 0, 0, 0};
    vt[12] = '{1, 8'h1C, 1, 1, 8'h1C, 1, 0, 0};
    vt[13] = '{1, 8'hE0, 1, 0, 8'h00, 0, 0, 0};
    vt[14] = '{1, 8'hF0, 1, 0, 8'h00, 0, 0, 0};
    vt[15] = '{1, 8'h1C, 1, 1, 8'h1C, 1, 1, 0};
    vt[16] = '{1, 8'hFA, 1, 0, 8'h00, 0, 0, 0};
    vt[17] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0};

    do_reset();
    chk("reset.valid", {31'd0, event_valid}, 32'd0);
    chk("reset.overflow", {31'd0, overflow}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      cyc(vt[i].sv, vt[i].code, vt[i].rdy);
      chk_ev($sformatf("vec%0d", i), vt[i].ev, vt[i].ec, vt[i].ee, vt[i].eb, vt[i].er);
    end
    chk("vec.overflow", {31'd0, overflow}, 32'd0);

    // Repeat timing: make at cycle 0, repeats at 10/14/18, resent make at 12, break lands at 22
    do_reset();
    cyc(1, 8'h1C, 1);
    chk_ev("rpt.make", 1, 8'h1C, 0, 0, 0);
    for (int k = 1; k <= 35; k++) begin
      if (k == 12) cyc(1, 8'h1C, 1);
      else if (k == 21) cyc(1, 8'hF0, 1);
      else if (k == 22) cyc(1, 8'h1C, 1);
      else cyc(0, 8'h00, 1);
      if (k == 22) chk_ev($sformatf("rpt.c%0d", k), 1, 8'h1C, 0, 1, 0);
      else if (k == 10 || k == 14 || k == 18) chk_ev($sformatf("rpt.c%0d", k), 1, 8'h1C, 0, 0, 1);
      else chk_ev($sformatf("rpt.c%0d", k), 0, 8'h00, 0, 0, 0);
    end

    // Overflow: six makes with no consumer, only the first four survive
    do_reset();
    keys[0] = 8'h15; keys[1] = 8'h1D; keys[2] = 8'h24;
    keys[3] = 8'h2D; keys[4] = 8'h2C; keys[5] = 8'h35;
    for (int i = 0; i < 6; i++) begin
      cyc(1, keys[i], 0);
      if (i == 3) chk("ovf.before", {31'd0, overflow}, 32'd0);
      if (i == 4) chk("ovf.after", {31'd0, overflow}, 32'd1);
    end
    cyc(1, 8'hF0, 0);
    cyc(1, 8'h35, 0);
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("ovf.drain%0d", i), 1, keys[i], 0, 0, 0);
      cyc(0, 8'h00, 1);
    end
    chk_ev("ovf.empty", 0, 8'h00, 0, 0, 0);
    chk("ovf.sticky", {31'd0, overflow}, 32'd1);

    // Full FIFO with a same-cycle pop and push
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, keys[i], 0);
    chk_ev("full.head", 1, 8'h15, 0, 0, 0);
    cyc(1, 8'h2C, 1);
    chk("full.overflow", {31'd0, overflow}, 32'd0);
    drain[0] = 8'h1D; drain[1] = 8'h24; drain[2] = 8'h2D; drain[3] = 8'h2C;
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("full.drain%0d", i), 1, drain[i], 0, 0, 0);
      cyc(0, 8'h00, 1);
    end
    chk_ev("full.empty", 0, 8'h00, 0, 0, 0);
    chk("full.overflow2", {31'd0, overflow}, 32'd0);

    // Repeat expiry collides with a break of another key
    do_reset();
    cyc(1, 8'h1C, 1);
    for (int k = 1; k <= 8; k++) cyc(0, 8'h00, 1);
    cyc(1, 8'hF0, 1);
    chk_ev("coll.c9", 0, 8'h00, 0, 0, 0);
    cyc(1, 8'h1D, 1);
    chk_ev("coll.break", 1, 8'h1D, 0, 1, 0);
    cyc(0, 8'h00, 1);
    chk_ev("coll.repeat", 1, 8'h1C, 0, 0, 1);
    cyc(0, 8'h00, 1);
    chk_ev("coll.empty", 0, 8'h00, 0, 0, 0);

    // Reset after E0 discards the prefix and buffered events
    do_reset();
    cyc(1, 8'h2C, 0);
    cyc(1, 8'hE0, 0);
    chk_ev("rst.buffered", 1, 8'h2C, 0, 0, 0);
    resetn = 1'b0;
    cyc(0, 8'h00, 0);
    resetn = 1'b1;
    chk("rst.valid", {31'd0, event_valid}, 32'd0);
    chk("rst.overflow", {31'd0, overflow}, 32'd0);
    cyc(1, 8'h1C, 0);
    chk_ev("rst.next", 1, 8'h1C, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequencing controller between the PS/2 byte receiver and game/input logic. Consumes raw scan-code bytes, runs the make/break/extended-prefix state machine, suppresses the keyboard's own typematic repeats and generates its own at parameterised delay/rate, and buffers the resulting key events in a small FIFO with a valid/ready handshake. It replaces ad-hoc "last byte == F0" checks downstream with one ordered event stream.

## Interface

**Parameters**

- REPEAT_DELAY, default 25000000: cycles from the make event to the first generated repeat (0.5 s at 50 MHz); must be ≥ 2.
- REPEAT_RATE, default 5000000: cycles between subsequent repeats; must be ≥ 2.
- FIFO_DEPTH, default 4: event FIFO entries; power of 2, ≥ 2.

**Ports**

- clock  in  1  single clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- scan_code  in  8  received PS/2 byte; valid only while scan_valid = 1.
- scan_valid  in  1  one-cycle strobe per received byte.
- event_ready  in  1  consumer accepts the head event this cycle.
- event_valid  out  1  FIFO non-empty.
- event_code  out  8  head event scan code (prefixes stripped).
- event_ext  out  1  head event had an E0 prefix.
- event_break  out  1  head event is a key release.
- event_repeat  out  1  head event was generated by the repeat timer.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation

- Decoder FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0). All transitions occur only on cycles with scan_valid = 1.
  - IDLE: E0→EXT; F0→BRK.
  - EXT: F0→EXT_BRK.
  - Any other byte in any state is a data byte: it forms an event {code, ext = state∈{EXT,EXT_BRK}, break = state∈{BRK,EXT_BRK}}, and the FSM returns to IDLE.
  - E0 in EXT or EXT_BRK, and F0 in BRK or EXT_BRK, keep the current state.
- Dropped bytes: 00, AA, E1, FA, FE and FF never form events. They force the FSM to IDLE.
- Held-key tracker: one register {held_valid, held_code, held_ext}.
  - Make event matching the held key: suppressed (keyboard typematic); nothing pushed; repeat timer unaffected.
  - Make event for any other key: pushed; the tracker loads that key; the timer loads REPEAT_DELAY−1.
  - Break event matching the held key: pushed; held_valid clears; the timer stops.
  - Break event for any other key: pushed; tracker and timer unchanged.
- Repeat timer: decrements each cycle while held_valid = 1.
  - On reaching 0, it raises a repeat request {held_code, held_ext, break = 0, repeat = 1} and reloads REPEAT_RATE−1.
- Push arbitration: at most one push per cycle.
  - A decoded event has priority over a repeat request.
  - A losing repeat request sets repeat_pending, which is pushed on the next cycle with no decoded event.
  - repeat_pending clears if held_valid clears or the held key changes before it is pushed.
- FIFO behaviour:
  - Pop when event_valid && event_ready.
  - Push while full without a same-cycle pop: the event is dropped and overflow is set.
  - Push while full with a same-cycle pop: both succeed and the count stays FIFO_DEPTH.
  - Pointer arithmetic wraps modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- Outputs event_code/ext/break/repeat are driven from the head entry. When event_valid = 0 their values are don't-care.

## Timing

- Reset (resetn = 0 at a posedge) sets:
  - FSM to IDLE.
  - held_valid, repeat_pending, timer, FIFO pointers and count to 0.
  - event_valid = 0 and overflow = 0.
- Reset mid-sequence (for example after E0) discards the partial prefix and all buffered events.
- Latency: a data byte strobed at cycle N with an empty FIFO gives event_valid = 1 at cycle N+1.
- Repeat timing: a make accepted at cycle N gives its first repeat push at cycle N+REPEAT_DELAY (visible at N+REPEAT_DELAY+1 if empty), then one push every REPEAT_RATE cycles.
- Handshake: the head event holds stable while event_valid = 1 and event_ready = 0. A pop at cycle N presents the next entry at N+1.
- scan_valid on consecutive cycles is legal. Each byte is processed in its own cycle.

## Test plan

- Byte 1C → one event {1C, ext 0, break 0, repeat 0}, event_valid at N+1. Bytes F0,1C → {1C, break 1}; the tracker clears.
- Bytes E0,F0,75 → {75, ext 1, break 1}, with no intermediate events. Bytes E0,AA,1C → only {1C, ext 0}.
- REPEAT_DELAY=10, REPEAT_RATE=4:
  - make 1C at cycle 0 with event_ready = 1 → repeat pushes at cycles 10, 14, 18.
  - keyboard re-sends 1C at cycle 12 → no extra event.
  - F0,1C → break event, and no further repeats.
- event_ready = 0, FIFO_DEPTH=4, six make codes for distinct keys → first four retained in order; overflow = 1 after the fifth; the FIFO drains four in order once event_ready = 1.
- Full FIFO, same-cycle pop and data byte → count stays 4, the new event is queued at the tail, and overflow remains 0.
- Repeat expiry in the same cycle as a break of another key → break pushed first and the repeat next cycle. Reset asserted after E0 → event_valid = 0, and the next byte 1C decodes with ext 0.
